// File: rtl/write_port_arbiter_if.sv
// Requester handshakes and the shared memory write port of write_port_arbiter.
// master: requester/writer side; slave: the arbiter.
interface write_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req0;
  logic [DATA_W-1:0] data0;
  logic              ack0;
  logic              req1;
  logic [DATA_W-1:0] data1;
  logic              ack1;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] address;
  logic              enable;
  logic              busy;
  logic              wrap0;
  logic              wrap1;

  modport master (
    output req0, data0, req1, data1,
    input  ack0, ack1, data, address, enable, busy, wrap0, wrap1
  );

  modport slave (
    input  req0, data0, req1, data1,
    output ack0, ack1, data, address, enable, busy, wrap0, wrap1
  );
endinterface

// File: rtl/write_port_arbiter.sv
// Two-requester arbiter for the single memory write port, one circular region per requester.
// Define WPA_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module write_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BASE0  = 0,
  parameter int BASE1  = 256,
  parameter int DEPTH  = 16
) (
  input logic                  clk,
  input logic                  reset,
  write_port_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE0_A = ADDR_W'(BASE0);
  localparam logic [ADDR_W-1:0] BASE1_A = ADDR_W'(BASE1);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t            state, state_n;
  logic [PTR_W-1:0]  ptr0, ptr0_n, ptr1, ptr1_n;
  logic              gnt, gnt_n;
  logic              win;
  logic [DATA_W-1:0] data_q, data_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              en_q, en_n;
  logic              ack0_q, ack0_n, ack1_q, ack1_n;
  logic              wrap0_q, wrap0_n, wrap1_q, wrap1_n;
  logic              busy_q, busy_n;

`ifdef WPA_ROUND_ROBIN_EN
  logic last, last_n;

  // On a tie the requester not granted most recently wins.
  always_comb win = (bus.req0 && bus.req1) ? ~last : bus.req1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last <= 1'b1;
    else       last <= last_n;
  end

  always_comb begin
    last_n = last;
    if (state == IDLE && (bus.req0 || bus.req1)) last_n = win;
  end
`else
  always_comb win = ~bus.req0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr0    <= '0;
      ptr1    <= '0;
      gnt     <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      wrap0_q <= 1'b0;
      wrap1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ptr0    <= ptr0_n;
      ptr1    <= ptr1_n;
      gnt     <= gnt_n;
      data_q  <= data_n;
      addr_q  <= addr_n;
      en_q    <= en_n;
      ack0_q  <= ack0_n;
      ack1_q  <= ack1_n;
      wrap0_q <= wrap0_n;
      wrap1_q <= wrap1_n;
      busy_q  <= busy_n;
    end
  end

  // Outputs are computed for the state being entered so every port is registered.
  always_comb begin
    state_n = state;
    ptr0_n  = ptr0;
    ptr1_n  = ptr1;
    gnt_n   = gnt;
    data_n  = data_q;
    addr_n  = addr_q;
    en_n    = 1'b0;
    ack0_n  = 1'b0;
    ack1_n  = 1'b0;
    wrap0_n = 1'b0;
    wrap1_n = 1'b0;
    busy_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_n = WRITE;
          gnt_n   = win;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          if (win) begin
            data_n = bus.data1;
            addr_n = BASE1_A + ADDR_W'(ptr1);
          end else begin
            data_n = bus.data0;
            addr_n = BASE0_A + ADDR_W'(ptr0);
          end
        end
      end
      WRITE: begin
        state_n = ACK;
        busy_n  = 1'b1;
        if (gnt) begin
          ack1_n  = 1'b1;
          wrap1_n = (ptr1 == '1);
          ptr1_n  = ptr1 + PTR_W'(1);
        end else begin
          ack0_n  = 1'b1;
          wrap0_n = (ptr0 == '1);
          ptr0_n  = ptr0 + PTR_W'(1);
        end
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.data    = data_q;
  assign bus.address = addr_q;
  assign bus.enable  = en_q;
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.wrap0   = wrap0_q;
  assign bus.wrap1   = wrap1_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_write_port_arbiter.sv
// Scoreboard bench for write_port_arbiter; follows WPA_ROUND_ROBIN_EN for the tie scenario.
module tb_write_port_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BASE0  = 0;
  localparam int BASE1  = 256;
  localparam int DEPTH  = 16;

  typedef struct {
    logic              who;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wrap;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  int unsigned ptr0_m = 0;
  int unsigned ptr1_m = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic cur_v = 1'b0;

  always #5 clk = ~clk;

  write_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  write_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE0(BASE0), .BASE1(BASE1), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic expect_write(input logic who, input logic [DATA_W-1:0] d);
    exp_t e;
    e.who  = who;
    e.data = d;
    if (who) begin
      e.addr = ADDR_W'(BASE1 + int'(ptr1_m));
      e.wrap = (ptr1_m == DEPTH - 1);
      ptr1_m = (ptr1_m + 1) % DEPTH;
    end else begin
      e.addr = ADDR_W'(BASE0 + int'(ptr0_m));
      e.wrap = (ptr0_m == DEPTH - 1);
      ptr0_m = (ptr0_m + 1) % DEPTH;
    end
    exp_q.push_back(e);
  endtask

  // Scoreboard: each write strobe pops one expected word; the following ack/wrap must match it.
  always @(negedge clk) begin
    if (reset) begin
      cur_v = 1'b0;
    end else begin
      if (bus.enable) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_write: unexpected write addr=%0d data=%h", bus.address, bus.data);
        end else begin
          cur   = exp_q.pop_front();
          cur_v = 1'b1;
          if (bus.address !== cur.addr || bus.data !== cur.data)
            $display("FAIL sb_write: got addr=%0d data=%h, want addr=%0d data=%h",
                     bus.address, bus.data, cur.addr, cur.data);
          else
            passed++;
        end
      end
      if (bus.ack0 || bus.ack1 || bus.wrap0 || bus.wrap1) begin
        checks++;
        if (!cur_v) begin
          $display("FAIL sb_ack: ack/wrap with no write in flight {ack1,ack0,wrap1,wrap0}=%b",
                   {bus.ack1, bus.ack0, bus.wrap1, bus.wrap0});
        end else if ({bus.ack1, bus.ack0, bus.wrap1, bus.wrap0} !==
                     {cur.who, ~cur.who, cur.who & cur.wrap, ~cur.who & cur.wrap}) begin
          $display("FAIL sb_ack: {ack1,ack0,wrap1,wrap0} got %b want %b",
                   {bus.ack1, bus.ack0, bus.wrap1, bus.wrap0},
                   {cur.who, ~cur.who, cur.who & cur.wrap, ~cur.who & cur.wrap});
        end else begin
          passed++;
        end
        cur_v = 1'b0;
      end
    end
  end

  task automatic apply_reset();
    reset  = 1'b1;
    ptr0_m = 0;
    ptr1_m = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_one(input logic who, input logic [DATA_W-1:0] d);
    expect_write(who, d);
    @(posedge clk); #1;
    if (who) begin bus.req1 = 1'b1; bus.data1 = d; end
    else     begin bus.req0 = 1'b1; bus.data0 = d; end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.enable, bus.busy} !== 2'b11)
      $display("FAIL write_strobe: {enable,busy} got %b want 11", {bus.enable, bus.busy});
    else passed++;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.ack1, bus.ack0, bus.enable} !== {who, ~who, 1'b0})
      $display("FAIL write_ack: {ack1,ack0,enable} got %b want %b",
               {bus.ack1, bus.ack0, bus.enable}, {who, ~who, 1'b0});
    else passed++;
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.ack0, bus.ack1} !== 3'b000)
      $display("FAIL write_idle: {busy,ack0,ack1} got %b want 000", {bus.busy, bus.ack0, bus.ack1});
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.data, bus.address, bus.enable, bus.ack0, bus.ack1, bus.wrap0, bus.wrap1, bus.busy} !== '0)
      $display("FAIL reset_hold: data=%h address=%h ctl=%b want all 0", bus.data, bus.address,
               {bus.enable, bus.ack0, bus.ack1, bus.wrap0, bus.wrap1, bus.busy});
    else passed++;
    apply_reset();
    @(negedge clk);
    checks++;
    if ({bus.enable, bus.busy, bus.address} !== '0)
      $display("FAIL reset_idle: enable=%b busy=%b address=%h want 0 0 0", bus.enable, bus.busy, bus.address);
    else passed++;
  endtask

  task automatic test_single();
    apply_reset();
    write_one(1'b0, 32'h0000_0007);
    checks++;
    if (bus.address !== 32'd0 || bus.data !== 32'h7)
      $display("FAIL single_hold: address=%0d data=%h want 0 00000007", bus.address, bus.data);
    else passed++;
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 17; i++) write_one(1'b1, 32'hA000 + 32'(i));
    checks++;
    if (bus.address !== 32'd256)
      $display("FAIL wrap_addr: 17th address got %0d want 256", bus.address);
    else passed++;
  endtask

  task automatic test_held();
    apply_reset();
    expect_write(1'b0, 32'h33);
    expect_write(1'b0, 32'h33);
    @(posedge clk); #1 bus.req0 = 1'b1; bus.data0 = 32'h33;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.enable !== 1'b1) $display("FAIL held_first: enable got %b want 1", bus.enable);
    else passed++;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.enable, bus.busy} !== 2'b00)
      $display("FAIL held_gap: {enable,busy} got %b want 00", {bus.enable, bus.busy});
    else passed++;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.enable !== 1'b1 || bus.address !== 32'd1)
      $display("FAIL held_second: enable=%b address=%0d want 1 1", bus.enable, bus.address);
    else passed++;
    @(posedge clk); @(negedge clk);
    @(posedge clk); #1 bus.req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_write();
    apply_reset();
    write_one(1'b0, 32'h11);
    expect_write(1'b0, 32'h22);
    @(posedge clk); #1 bus.req0 = 1'b1; bus.data0 = 32'h22;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.enable !== 1'b1 || bus.address !== 32'd1)
      $display("FAIL rst_write_pre: enable=%b address=%0d want 1 1", bus.enable, bus.address);
    else passed++;
    #1 reset = 1'b1;
    ptr0_m = 0;
    ptr1_m = 0;
    #1;
    checks++;
    if ({bus.enable, bus.busy, bus.data, bus.address} !== '0)
      $display("FAIL rst_write_now: enable=%b busy=%b data=%h address=%h want all 0",
               bus.enable, bus.busy, bus.data, bus.address);
    else passed++;
    @(negedge clk);
    checks++;
    if ({bus.ack0, bus.ack1} !== 2'b00)
      $display("FAIL rst_write_noack: {ack0,ack1} got %b want 00", {bus.ack0, bus.ack1});
    else passed++;
    expect_write(1'b0, 32'h22);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.enable !== 1'b1 || bus.address !== 32'd0)
      $display("FAIL rst_write_retry: enable=%b address=%0d want 1 0", bus.enable, bus.address);
    else passed++;
    @(posedge clk); @(negedge clk);
    @(posedge clk); #1 bus.req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.data0 = 32'hD0D0;
    bus.data1 = 32'hD1D1;
    reset     = 1'b1;
    ptr0_m    = 0;
    ptr1_m    = 0;
`ifdef WPA_ROUND_ROBIN_EN
    expect_write(1'b0, 32'hD0D0);
    expect_write(1'b1, 32'hD1D1);
    expect_write(1'b0, 32'hD0D0);
    expect_write(1'b1, 32'hD1D1);
`else
    for (int i = 0; i < 4; i++) expect_write(1'b0, 32'hD0D0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.enable !== ((i % 3) == 0))
        $display("FAIL tie_cadence: cycle %0d enable got %b want %b", i, bus.enable, (i % 3) == 0);
      else passed++;
    end
    bus.req0 = 1'b0;
`ifdef WPA_ROUND_ROBIN_EN
    bus.req1 = 1'b0;
`else
    expect_write(1'b1, 32'hD1D1);
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.enable !== 1'b1 || bus.address !== 32'd256)
      $display("FAIL tie_late1: enable=%b address=%0d want 1 256", bus.enable, bus.address);
    else passed++;
    @(posedge clk); @(negedge clk);
    @(posedge clk); #1 bus.req1 = 1'b0;
`endif
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL tie_done: busy got %b want 0", bus.busy);
    else passed++;
  endtask

  initial begin
    reset     = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    test_reset();
    test_single();
    test_wrap();
    test_held();
    test_reset_in_write();
    test_tie();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || cur_v)
      $display("FAIL sb_drain: %0d writes never seen, ack pending=%b", exp_q.size(), cur_v);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
